serial_adder_fsm: RTL and testbench

Bit-serial adder that adds two WIDTH-bit operands plus a carry-in, one bit per clock, using a single `full_adder_structural` instance as its datapath. It is the sequential stage that drives the existing one-bit full adder. Operand shift registers feed A/B, a carry flip-flop closes Cout back to Cin, and S is collected into a result shift register. A start/busy/done handshake sequences it for the control logic upstream.

---
 rtl/serial_adder_fsm.sv | 153 +++++++++++++++
 tb/tb_serial_adder_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one full adder, operand/result shift registers and a
// start/busy/done sequencer. Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module full_adder_structural (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    logic axb;
    logic gen;
    logic prop;

    xor u_x1 (axb, A, B);
    xor u_x2 (S, axb, Cin);
    and u_a1 (gen, A, B);
    and u_a2 (prop, axb, Cin);
    or  u_o1 (Cout, gen, prop);
endmodule

module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_a_q;
    logic [WIDTH-1:0] shift_b_q;
    logic [WIDTH-1:0] shift_s_q;
    logic [WIDTH-1:0] shift_s_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_s;
    logic             fa_cout;

    full_adder_structural u_fa (
        .A    (shift_a_q[0]),
        .B    (shift_b_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // The new sum bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
    assign shift_s_d = {fa_s, shift_s_q[WIDTH-1:1]};

`ifdef SERIAL_ADDER_OVF_EN
    // The operand MSBs are shifted out during RUN, so they are kept aside at capture.
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if (state_q == S_RUN && cnt_q == LAST_BIT) begin
            ovf_q <= (a_msb_q == b_msb_q) && (fa_s != a_msb_q);
        end
    end

    assign ovf = ovf_q;
`endif

    // NOTE: all state, shift registers included, is cleared asynchronously and updated with
    // non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            shift_s_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shift_a_q <= a;
                        shift_b_q <= b;
                        carry_q   <= cin;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    shift_a_q <= shift_a_q >> 1;
                    shift_b_q <= shift_b_q >> 1;
                    shift_s_q <= shift_s_d;
                    carry_q   <= fa_cout;
                    cnt_q     <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= shift_s_d;
                        cout_q  <= fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_fsm.sv
// Randomized and directed bench for serial_adder_fsm against an arithmetic reference model.
// Define SERIAL_ADDER_OVF_EN for both files to also check ovf.

module tb_serial_adder_fsm;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    function automatic logic model_ovf(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci);
        int s;
        s = int'($signed(ta)) + int'($signed(tb)) + int'(tci);
        return (s > 2 ** (W - 1) - 1) || (s < -(2 ** (W - 1)));
    endfunction
`endif

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic do_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tci, input bit poke_busy);
        logic [W:0]   exp;
        logic [W-1:0] prev_sum;
        logic         prev_cout;
        int           busy_n, done_n, done_at;
        bit           held_ok, overlap;

        exp       = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tci};
        prev_sum  = sum;
        prev_cout = cout;
        a = ta; b = tb; cin = tci; start = 1'b1;
        busy_n = 0; done_n = 0; done_at = 0; held_ok = 1; overlap = 0;
        for (int c = 1; c <= W + 3; c++) begin
            @(negedge clk);
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            if (poke_busy && c == 3) begin
                start = 1'b1;
                a = 8'hAA;
                b = 8'hAA;
            end else begin
                start = 1'b0;
            end
            busy_n += int'(busy);
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = c;
            end
            if (busy && done) overlap = 1;
            if (done_at == 0 && !done && (sum !== prev_sum || cout !== prev_cout)) held_ok = 0;
        end
        check({tag, ".busy_cycles"}, busy_n, W);
        check({tag, ".done_count"}, done_n, 1);
        check({tag, ".done_cycle"}, done_at, W + 1);
        check({tag, ".overlap"}, overlap, 0);
        check({tag, ".held"}, held_ok, 1);
        check({tag, ".sum"}, sum, exp[W-1:0]);
        check({tag, ".cout"}, cout, exp[W]);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"}, ovf, model_ovf(ta, tb, tci));
`endif
    endtask

    initial begin
        int d1, d2, dn;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.sum", sum, 0);
        check("rst.cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst.ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        do_add("basic", 8'h5A, 8'h3C, 1'b0, 0);
        do_add("chain", 8'hFF, 8'h01, 1'b0, 0);
        do_add("chain_cin", 8'hFF, 8'h00, 1'b1, 0);
        do_add("start_busy", 8'h10, 8'h20, 1'b0, 1);

        // Start held high: re-accepted on the first IDLE cycle after DONE.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        d1 = 0; d2 = 0; dn = 0;
        for (int c = 1; c <= 2 * W + 3; c++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (d1 == 0) d1 = c;
                else d2 = c;
            end
        end
        start = 1'b0;
        check("hold.done_count", dn, 2);
        check("hold.first_done", d1, W + 1);
        check("hold.second_done", d2, 2 * W + 3);
        check("hold.sum", sum, 8'h46);
        @(negedge clk);

        // Reset in the middle of a run clears outputs without a clock edge.
        a = 8'h55; b = 8'h11; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.sum", sum, 0);
        check("midrst.cout", cout, 0);
        check("midrst.done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < W + 3; c++) begin
            @(negedge clk);
            dn += int'(done);
        end
        check("midrst.no_done", dn, 0);
        do_add("after_rst", 8'h01, 8'h01, 1'b0, 0);

        do_add("ovf_pos", 8'h7F, 8'h01, 1'b0, 0);
        do_add("ovf_neg", 8'h80, 8'h80, 1'b0, 0);
        do_add("ovf_mix", 8'h7F, 8'h80, 1'b0, 0);

        for (int i = 0; i < 30; i++)
            do_add("rand", W'($urandom), W'($urandom), 1'($urandom), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
